// File: rtl/parity_frame_rx_if.sv
// Bundles the serial line and the received-frame outputs of parity_frame_rx.
// The master side is the receiver; the slave side is whoever drives rxd and
// consumes the byte and its status.
interface parity_frame_rx_if;
    logic       rxd;
    logic [7:0] b;
    logic       par_bit;
    logic       valid;
    logic       par_err;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rxd,
        output b, par_bit, valid, par_err, frame_err, busy
    );

    modport slave (
        output rxd,
        input  b, par_bit, valid, par_err, frame_err, busy
    );
endinterface

// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start bit, 8 data bits LSB first, parity bit, stop bit.
// Presents the assembled byte and parity bit to the downstream parity checker
// with a one-cycle valid strobe, and flags parity/framing errors locally.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a falling edge on the synchronized line
// START  | timing to mid start bit, confirming the line is still low
// DATA   | sampling the 8 data bits at mid-bit points
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then publishing the frame
module parity_frame_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    parity_frame_rx_if.master  bus
);

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    sr_q, sr_d;
    logic          par_q, par_d;
    logic          done;

    logic          rxd_meta_q, rs_q, rs_d_q;
    logic [7:0]    b_q;
    logic          par_bit_q, valid_q, par_err_q, frame_err_q;

    // Two-flop synchronizer for the asynchronous line plus one delay for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q <= 1'b1;
            rs_q       <= 1'b1;
            rs_d_q     <= 1'b1;
        end else begin
            rxd_meta_q <= bus.rxd;
            rs_q       <= rxd_meta_q;
            rs_d_q     <= rs_q;
        end
    end

    // FSM and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sr_q    <= '0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sr_q    <= sr_d;
            par_q   <= par_d;
        end
    end

    // Next-state logic; cnt is a down-counter reloaded at every sample point.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        par_d   = par_q;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (rs_d_q && !rs_q) begin
                    state_d = START;
                    cnt_d   = HALF_LAST;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rs_q) begin
                        state_d = DATA;
                        cnt_d   = BIT_LAST;
                        idx_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    sr_d  = {rs_q, sr_q[7:1]};
                    cnt_d = BIT_LAST;
                    idx_d = idx_q + 1'b1;
                    if (idx_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rs_q;
                    cnt_d   = BIT_LAST;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Published outputs only change when a frame completes its stop sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q         <= '0;
            par_bit_q   <= 1'b0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q <= done;
            if (done) begin
                b_q         <= sr_q;
                par_bit_q   <= par_q;
                par_err_q   <= (^sr_q) ^ par_q ^ PARITY_ODD;
                frame_err_q <= ~rs_q;
            end
        end
    end

    assign bus.b         = b_q;
    assign bus.par_bit   = par_bit_q;
    assign bus.valid     = valid_q;
    assign bus.par_err   = par_err_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// Bench for parity_frame_rx: an even-parity and an odd-parity instance share
// one serial line. Frame contents are checked against a table of hand-derived
// results, against a queue-based reference model for random frames, and by
// hand-written sequences for glitch, framing-error, reset and back-to-back cases.
module tb_parity_frame_rx;

    localparam int CPB = 16;
    localparam int H   = CPB / 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rxd   = 1'b1;

    always #5 clk = ~clk;

    parity_frame_rx_if if_e ();
    parity_frame_rx_if if_o ();
    assign if_e.rxd = rxd;
    assign if_o.rxd = rxd;

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_e.master)
    );

    parity_frame_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b1)) dut_o (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_o.master)
    );

    typedef struct {
        logic [7:0] b;
        logic       par_bit;
        logic       par_err;
        logic       frame_err;
    } obs_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] exp_b;
        logic       exp_pe_even;
        logic       exp_pe_odd;
        logic       exp_fe;
    } vec_t;

    obs_t   obs_e[$], obs_o[$], exp_e[$], exp_o[$];
    obs_t   mon_e, mon_o;
    vec_t   vecs[6];
    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint vcyc = 0;
    longint start_cyc;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every valid pulse of each instance.
    always @(negedge clk) begin
        if (if_e.valid === 1'b1) begin
            mon_e.b = if_e.b; mon_e.par_bit = if_e.par_bit;
            mon_e.par_err = if_e.par_err; mon_e.frame_err = if_e.frame_err;
            obs_e.push_back(mon_e);
            vcyc = cyc;
        end
        if (if_o.valid === 1'b1) begin
            mon_o.b = if_o.b; mon_o.par_bit = if_o.par_bit;
            mon_o.par_err = if_o.par_err; mon_o.frame_err = if_o.frame_err;
            obs_o.push_back(mon_o);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
    endtask

    // Reference model: parity error is an odd count of ones over data plus
    // parity bit for even mode, an even count for odd mode.
    task automatic expect_frame(input logic [7:0] d, input logic p, input logic s);
        obs_t e, o;
        int ones;
        ones = $countones(d) + int'(p);
        e.b = d; e.par_bit = p; e.frame_err = !s;
        o = e;
        e.par_err = (ones % 2) != 0;
        o.par_err = (ones % 2) == 0;
        exp_e.push_back(e);
        exp_o.push_back(o);
    endtask

    task automatic compare_queues(input string name);
        int n;
        check($sformatf("%s count_even", name), obs_e.size(), exp_e.size());
        check($sformatf("%s count_odd", name), obs_o.size(), exp_o.size());
        n = (obs_e.size() < exp_e.size()) ? obs_e.size() : exp_e.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d] b", name, i), obs_e[i].b, exp_e[i].b);
            check($sformatf("%s[%0d] par_bit", name, i), obs_e[i].par_bit, exp_e[i].par_bit);
            check($sformatf("%s[%0d] par_err_even", name, i), obs_e[i].par_err, exp_e[i].par_err);
            check($sformatf("%s[%0d] frame_err", name, i), obs_e[i].frame_err, exp_e[i].frame_err);
        end
        n = (obs_o.size() < exp_o.size()) ? obs_o.size() : exp_o.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s[%0d] b_odd", name, i), obs_o[i].b, exp_o[i].b);
            check($sformatf("%s[%0d] par_err_odd", name, i), obs_o[i].par_err, exp_o[i].par_err);
        end
        obs_e.delete(); obs_o.delete(); exp_e.delete(); exp_o.delete();
    endtask

    task automatic check_reset_values(input string name);
        check({name, " b_even"}, if_e.b, 8'h00);
        check({name, " b_odd"}, if_o.b, 8'h00);
        check({name, " par_bit"}, if_e.par_bit, 1'b0);
        check({name, " valid"}, {if_e.valid, if_o.valid}, 2'b00);
        check({name, " par_err"}, {if_e.par_err, if_o.par_err}, 2'b00);
        check({name, " frame_err"}, {if_e.frame_err, if_o.frame_err}, 2'b00);
        check({name, " busy"}, {if_e.busy, if_o.busy}, 2'b00);
    endtask

    initial begin
        int busy_e, busy_o;
        logic [7:0] d;
        logic p, s, prev_stop;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            obs_e.delete(); obs_o.delete();
            start_cyc = cyc;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            send_bit(1'b1);
            send_bit(1'b1);
            #1;
            check($sformatf("vec%0d pulses_even", i), obs_e.size(), 1);
            check($sformatf("vec%0d pulses_odd", i), obs_o.size(), 1);
            check($sformatf("vec%0d b", i), if_e.b, vecs[i].exp_b);
            check($sformatf("vec%0d b_odd", i), if_o.b, vecs[i].exp_b);
            check($sformatf("vec%0d par_bit", i), if_e.par_bit, vecs[i].par);
            check($sformatf("vec%0d par_err_even", i), if_e.par_err, vecs[i].exp_pe_even);
            check($sformatf("vec%0d par_err_odd", i), if_o.par_err, vecs[i].exp_pe_odd);
            check($sformatf("vec%0d frame_err", i), {if_e.frame_err, if_o.frame_err},
                  {vecs[i].exp_fe, vecs[i].exp_fe});
            check($sformatf("vec%0d valid_low", i), {if_e.valid, if_o.valid}, 2'b00);
            if (i == 0)
                check("clean valid latency", 32'(vcyc - start_cyc), 32'(H + 10 * CPB + 3));
        end
        obs_e.delete(); obs_o.delete();

        // Framing error followed by a long low line
        send_frame(8'h3C, 1'b0, 1'b0);
        busy_e = 0; busy_o = 0;
        repeat (50 * CPB) begin
            @(negedge clk);
            if (if_e.busy === 1'b1) busy_e++;
            if (if_o.busy === 1'b1) busy_o++;
        end
        #1;
        check("frame_err pulses", obs_e.size(), 1);
        check("frame_err flag", {if_e.frame_err, if_o.frame_err}, 2'b11);
        check("frame_err b", if_e.b, 8'h3C);
        check("frame_err busy while low", busy_e + busy_o, 0);
        send_bit(1'b1);
        send_bit(1'b1);
        #1;
        check("frame_err no extra pulse", obs_e.size() + obs_o.size(), 2);
        obs_e.delete(); obs_o.delete();

        // Start glitch: 4 clocks low
        busy_e = 0; busy_o = 0;
        rxd = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 3) rxd = 1'b1;
            if (if_e.busy === 1'b1) busy_e++;
            if (if_o.busy === 1'b1) busy_o++;
        end
        #1;
        check("glitch busy_even cycles", busy_e, H);
        check("glitch busy_odd cycles", busy_o, H);
        check("glitch no valid", obs_e.size() + obs_o.size(), 0);
        check("glitch held b", if_e.b, 8'h3C);
        check("glitch held frame_err", if_e.frame_err, 1'b1);

        // Reset in the middle of data bit 3
        d = 8'h96;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(d[i]);
        rxd = d[3];
        repeat (CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        send_bit(1'b1);
        send_bit(1'b1);
        expect_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_bit(1'b1);
        #1;
        compare_queues("reset_recover");

        // Back-to-back frames, no idle time between them
        expect_frame(8'h00, 1'b1, 1'b1);
        expect_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_bit(1'b1);
        #1;
        compare_queues("b2b");

        // Random frames against the reference model
        prev_stop = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 5) != 0);
            if (!prev_stop || $urandom_range(0, 1) == 1)
                send_bit(1'b1);
            expect_frame(d, p, s);
            send_frame(d, p, s);
            prev_stop = s;
        end
        send_bit(1'b1);
        #1;
        compare_queues("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parity_frame_rx.md
# parity_frame_rx

Serial frame receiver that sits directly upstream of the 8-bit parity checker. Samples an asynchronous serial line carrying frames of one start bit, 8 data bits (LSB first), one parity bit and one stop bit. Presents the assembled byte on `b[7:0]` for the checker, together with the received parity bit and a one-cycle valid strobe. Also flags parity and framing errors locally, so the frame status is available without the checker.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit.
  - Legal values are integers ≥ 4.
  - `H = CLKS_PER_BIT/2`, using integer division.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd parity.
- `clk` input 1: single clock; everything is sampled on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `rxd` input 1: serial line, asynchronous to `clk`, idles high.
- `b` output 8: last received data byte; drives the parity checker's `b` input.
- `par_bit` output 1: last received parity bit.
- `valid` output 1: one-cycle pulse when `b`, `par_bit`, `par_err` and `frame_err` update.
- `par_err` output 1: received parity does not match the `PARITY_ODD` setting.
- `frame_err` output 1: stop bit was sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer:** `rxd` passes through 2 flops, both reset to 1. All logic below uses the synchronized value `rs`. A third flop `rs_d` (reset 1) holds the previous `rs` for edge detection.
- **FSM states:** IDLE, START, DATA, PARITY, STOP. A single bit counter `cnt` and a 3-bit bit index `idx` drive the transitions.
- **IDLE:**
  - Waits for a falling edge: `rs_d`=1 and `rs`=0.
  - On that edge: go to START with `cnt`=0.
  - A line held low never starts a frame.
- **START:**
  - Count to `cnt`=H−1, the mid-start-bit point.
  - If `rs`=0 there: go to DATA with `cnt`=0, `idx`=0.
  - If `rs`=1 there: the edge was a glitch; return to IDLE with no output change.
- **DATA:**
  - At `cnt`=CLKS_PER_BIT−1: shift `rs` into bit `idx` of the shift register (LSB first) and clear `cnt`.
  - After `idx`=7 is sampled: go to PARITY.
- **PARITY:** at `cnt`=CLKS_PER_BIT−1, capture `rs` as the parity sample and go to STOP.
- **STOP:** at `cnt`=CLKS_PER_BIT−1, sample the stop bit, then go to IDLE and on the same edge register:
  - `b` ← shift register.
  - `par_bit` ← parity sample.
  - `par_err` ← (XOR of the 8 data bits ^ parity sample) ^ `PARITY_ODD`.
  - `frame_err` ← ~stop sample.
  - `valid` ← 1.
- **Output hold:**
  - `valid` is high for exactly one cycle per completed frame.
  - `b`, `par_bit`, `par_err` and `frame_err` hold their values until the next completed frame.
- **Frames that do not complete** (glitch aborts, reset) never pulse `valid` and never modify the held outputs.
- **Framing error (stop bit low):**
  - The frame is still reported, with `valid`=1 and `frame_err`=1.
  - The FSM returns to IDLE.
  - No new frame starts until the line goes high and then falls again.
- **Back-to-back frames:** a start edge arriving in the first IDLE cycle after STOP is accepted, so zero idle time between frames is supported.
- **Counter width:** `cnt` is wide enough for CLKS_PER_BIT−1. It never wraps inside a state because it is cleared at each sample point.

## Timing
- **Reset values:**
  - `b`=0x00, `par_bit`=0, `valid`=0, `par_err`=0, `frame_err`=0, `busy`=0.
  - FSM in IDLE, synchronizer flops at 1.
- **Reset mid-frame:** `rst_n` low at any point clears everything to the reset values immediately (asynchronously). No `valid` is produced for the interrupted frame.
- **Synchronizer latency:** 2 clocks from `rxd` to `rs`.
- **Sample points:** edge 0 is the edge that leaves IDLE. The samples are:
  - Start-bit check at edge H.
  - Data bit k at edge H + (k+1)·CLKS_PER_BIT, for k = 0..7.
  - Parity at edge H + 9·CLKS_PER_BIT.
  - Stop at edge H + 10·CLKS_PER_BIT.
- **Output timing:**
  - `valid` and the updated outputs are visible in the cycle following the stop-sample edge.
  - `busy` falls in that same cycle.
- **`busy`:** rises in the cycle after edge 0. On a glitch abort it falls in the cycle after edge H.

## Test plan
All scenarios use CLKS_PER_BIT=16 (H=8) and PARITY_ODD=0 unless stated otherwise.
- **Clean frame:** send 0xA5 with parity 0 and stop 1 → one `valid` pulse, `b`=0xA5, `par_bit`=0, `par_err`=0, `frame_err`=0. The `valid` cycle matches edge H+160 +1 exactly.
- **Bad parity:** send 0x07 with parity bit 0 → `valid` pulses, `b`=0x07, `par_err`=1, `frame_err`=0.
- **Framing error:** send 0x3C with stop bit 0, then hold `rxd` low for 50 bit times → exactly one `valid` with `frame_err`=1. No further `valid` and `busy`=0 until `rxd` rises and falls again.
- **Start glitch:** drive `rxd` low for 4 clocks, then high → no `valid`, held outputs unchanged, `busy` high for 8 cycles then 0.
- **Reset mid-frame:** assert `rst_n` low in the middle of data bit 3 → all outputs read the reset values immediately. The next frame, 0x5A with parity 0, is then received correctly.
- **Back-to-back, odd parity:** with PARITY_ODD=1, send 0x00 with parity 1 immediately followed by 0xFF with parity 1 → two `valid` pulses carrying 0x00 and then 0xFF, both with `par_err`=0.
